// File: rtl/bf16_pkg.sv
// Shared types and constants for FP32 -> BF16 narrowing.
package bf16_pkg;

   localparam int unsigned FP32_W     = 32;
   localparam int unsigned BF16_W     = 16;
   localparam int unsigned FP32_EXP_W = 8;
   localparam int unsigned FP32_MAN_W = 23;
   localparam int unsigned BF16_MAN_W = 7;
   localparam int unsigned GUARD_BIT  = FP32_MAN_W - BF16_MAN_W - 1;
   localparam int unsigned EK_W       = FP32_EXP_W + BF16_MAN_W;

   localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7FC0;

   typedef enum logic [2:0] {
      RND_RNE = 3'd0,
      RND_RTZ = 3'd1,
      RND_RDN = 3'd2,
      RND_RUP = 3'd3,
      RND_RMM = 3'd4
   } rnd_mode_e;

   typedef enum logic [2:0] {
      CLS_ZERO = 3'd0,
      CLS_SUB  = 3'd1,
      CLS_NORM = 3'd2,
      CLS_INF  = 3'd3,
      CLS_QNAN = 3'd4,
      CLS_SNAN = 3'd5
   } fp_class_e;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   // Stage-1 payload: everything stage 2 needs to form the result.
   typedef struct packed {
      logic                  sign;
      logic [FP32_EXP_W-1:0] exp;
      logic [BF16_MAN_W-1:0] kept;
      logic                  guard;
      logic                  sticky;
      logic                  inc;
      fp_class_e             cls;
   } s1_payload_t;

   function automatic fp_class_e fp32_classify(input logic [FP32_EXP_W-1:0] e,
                                               input logic [FP32_MAN_W-1:0] m);
      if (e == '0) begin
         if (m == '0) return CLS_ZERO;
         return CLS_SUB;
      end
      if (e == '1) begin
         if (m == '0) return CLS_INF;
         if (m[FP32_MAN_W-1]) return CLS_QNAN;
         return CLS_SNAN;
      end
      return CLS_NORM;
   endfunction

endpackage

// File: rtl/bf16_round_decide.sv
// Round-increment decision for a narrowing conversion; reserved modes round to nearest even.
module bf16_round_decide
   import bf16_pkg::*;
(
   input  logic       sign,
   input  logic       lsb,
   input  logic       guard,
   input  logic       sticky,
   input  logic [2:0] rnd_mode,
   output logic       inc
);

   always_comb begin
      inc = guard & (sticky | lsb);
      case (rnd_mode)
         RND_RTZ: inc = 1'b0;
         RND_RDN: inc = sign & (guard | sticky);
         RND_RUP: inc = ~sign & (guard | sticky);
         RND_RMM: inc = guard;
         default: ;
      endcase
   end

endmodule

// File: rtl/fp32_to_bf16_pipe.sv
// Two-stage FP32 -> BF16 converter with IEEE rounding, exception flags and valid/ready flow control.
module fp32_to_bf16_pipe
   import bf16_pkg::*;
#(
   parameter bit FTZ = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FP32_W-1:0] operand_a,
   input  logic [2:0]        rnd_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BF16_W-1:0] result,
   output logic              invalid,
   output logic              overflow,
   output logic              underflow,
   output logic              inexact
);

   logic              s2_load;
   logic              s1_load;
   logic              in_inc;
   s1_payload_t       in_pay;

   logic              s1_valid_q, s1_valid_d;
   s1_payload_t       s1_pay_q, s1_pay_d;
   logic              s2_valid_q, s2_valid_d;
   logic [BF16_W-1:0] result_q, result_d;
   fp_flags_t         flags_q, flags_d;

   logic [EK_W-1:0]   ek_sum;
   logic [BF16_W-1:0] conv_res;
   fp_flags_t         conv_flg;

   bf16_round_decide u_round (
      .sign     (operand_a[FP32_W-1]),
      .lsb      (operand_a[GUARD_BIT+1]),
      .guard    (operand_a[GUARD_BIT]),
      .sticky   (|operand_a[GUARD_BIT-1:0]),
      .rnd_mode (rnd_mode),
      .inc      (in_inc)
   );

   // Field split and classification of the incoming operand.
   always_comb begin
      in_pay.sign   = operand_a[FP32_W-1];
      in_pay.exp    = operand_a[FP32_W-2 -: FP32_EXP_W];
      in_pay.kept   = operand_a[FP32_MAN_W-1 -: BF16_MAN_W];
      in_pay.guard  = operand_a[GUARD_BIT];
      in_pay.sticky = |operand_a[GUARD_BIT-1:0];
      in_pay.inc    = in_inc;
      in_pay.cls    = fp32_classify(operand_a[FP32_W-2 -: FP32_EXP_W],
                                    operand_a[FP32_MAN_W-1:0]);
   end

   // Pipeline advance: stage 2 drains on out_ready, stage 1 follows stage 2.
   always_comb begin
      s2_load  = !s2_valid_q || out_ready;
      s1_load  = !s1_valid_q || s2_load;
      in_ready = s1_load;

      s1_valid_d = s1_valid_q;
      s1_pay_d   = s1_pay_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) s1_pay_d = in_pay;
      end
   end

   // Result formation from the stage-1 payload.
   always_comb begin
      ek_sum   = {s1_pay_q.exp, s1_pay_q.kept} + EK_W'(s1_pay_q.inc);
      conv_res = {s1_pay_q.sign, ek_sum};
      conv_flg = '0;
      case (s1_pay_q.cls)
         CLS_ZERO: conv_res = {s1_pay_q.sign, 15'b0};
         CLS_INF:  conv_res = {s1_pay_q.sign, 8'hFF, 7'b0};
         CLS_QNAN: conv_res = BF16_QNAN;
         CLS_SNAN: begin
            conv_res         = BF16_QNAN;
            conv_flg.invalid = 1'b1;
         end
         default: begin
            if (FTZ && (s1_pay_q.cls == CLS_SUB)) begin
               conv_res           = {s1_pay_q.sign, 15'b0};
               conv_flg.underflow = 1'b1;
               conv_flg.inexact   = 1'b1;
            end else begin
               conv_flg.inexact = s1_pay_q.guard | s1_pay_q.sticky;
               // Rounding carried into an all-ones exponent: saturate to infinity.
               if (ek_sum[EK_W-1 -: FP32_EXP_W] == '1) begin
                  conv_res          = {s1_pay_q.sign, 8'hFF, 7'b0};
                  conv_flg.overflow = 1'b1;
                  conv_flg.inexact  = 1'b1;
               end
               conv_flg.underflow = (s1_pay_q.exp == '0) & conv_flg.inexact;
            end
         end
      endcase

      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      flags_d    = flags_q;
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = conv_res;
            flags_d  = conv_flg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_pay_q   <= '0;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_pay_q   <= s1_pay_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign result    = result_q;
   assign invalid   = flags_q.invalid;
   assign overflow  = flags_q.overflow;
   assign underflow = flags_q.underflow;
   assign inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp32_to_bf16_pipe.sv
// Bench for fp32_to_bf16_pipe: FTZ=0 and FTZ=1 instances share stimulus and a scoreboard.
module tb_fp32_to_bf16_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] operand_a = '0;
   logic [2:0]  rnd_mode = '0;
   logic        out_ready = 1'b1;
   logic [1:0]  in_ready_w;
   logic [1:0]  out_valid_w;
   logic [15:0] res0, res1;
   logic [3:0]  flg0, flg1;

   int n_vec = 0;
   int n_fail = 0;
   bit rst_seen = 1'b0;
   logic [39:0] sb [$];

   always #5 clk = ~clk;

   fp32_to_bf16_pipe #(.FTZ(1'b0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .operand_a(operand_a), .rnd_mode(rnd_mode), .out_valid(out_valid_w[0]),
      .out_ready(out_ready), .result(res0), .invalid(flg0[3]), .overflow(flg0[2]),
      .underflow(flg0[1]), .inexact(flg0[0])
   );

   fp32_to_bf16_pipe #(.FTZ(1'b1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .operand_a(operand_a), .rnd_mode(rnd_mode), .out_valid(out_valid_w[1]),
      .out_ready(out_ready), .result(res1), .invalid(flg1[3]), .overflow(flg1[2]),
      .underflow(flg1[1]), .inexact(flg1[0])
   );

   function automatic void chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endfunction

   // Reference: integer rounding of the magnitude, {invalid,overflow,underflow,inexact,result}.
   function automatic logic [19:0] model(input logic [31:0] a, input logic [2:0] rm, input bit ftz);
      int unsigned mag, trunc, rem, r;
      bit          sgn, up;
      logic [7:0]  e;
      sgn   = a[31];
      e     = a[30:23];
      mag   = {1'b0, a[30:0]};
      trunc = mag >> 16;
      rem   = mag & 32'h0000_FFFF;
      if (e == 8'hFF) begin
         if (a[22:0] == 23'd0) return {4'b0000, sgn, 15'h7F80};
         if (a[22]) return {4'b0000, 16'h7FC0};
         return {4'b1000, 16'h7FC0};
      end
      if (mag == 0) return {4'b0000, sgn, 15'h0000};
      if (e == 8'h00 && ftz) return {4'b0011, sgn, 15'h0000};
      case (rm)
         3'd1:    up = 1'b0;
         3'd2:    up = sgn && (rem != 0);
         3'd3:    up = !sgn && (rem != 0);
         3'd4:    up = (rem >= 32'h8000);
         default: up = (rem > 32'h8000) || ((rem == 32'h8000) && (trunc % 2 == 1));
      endcase
      r = trunc + 32'(up);
      if (r >= 32'h7F80) return {4'b0101, sgn, 15'h7F80};
      return {1'b0, 1'b0, (e == 8'h00) && (rem != 0), rem != 0, sgn, r[14:0]};
   endfunction

   localparam int NT = 16;
   localparam logic [31:0] TAB_A [NT] = '{
      32'h3F800000, 32'h3F808000, 32'h3F818000, 32'h3F81FFFF, 32'h3F81FFFF, 32'h7F7FFFFF,
      32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7FA00000, 32'hFFC00001, 32'hFF800000, 32'h00000001,
      32'h00000001, 32'h00000001, 32'h3F808000, 32'h3F818000};
   localparam logic [2:0] TAB_RM [NT] = '{
      3'd0, 3'd0, 3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd4, 3'd7};
   localparam bit TAB_FTZ [NT] = '{
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [19:0] TAB_EXP [NT] = '{
      20'h0_3F80, 20'h1_3F80, 20'h1_3F82, 20'h1_3F81, 20'h1_3F82, 20'h5_7F80,
      20'h1_7F7F, 20'h5_FF80, 20'h8_7FC0, 20'h0_7FC0, 20'h0_FF80, 20'h3_0000,
      20'h3_0001, 20'h3_0000, 20'h1_3F81, 20'h1_3F82};

   // Scoreboard and output compare, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         rst_seen = 1'b1;
      end else begin
         if (rst_seen) begin
            chk("post_reset_out_valid", 40'(out_valid_w), 40'h0);
            chk("post_reset_in_ready", 40'(in_ready_w), 40'h3);
            chk("post_reset_outputs", {flg1, res1, flg0, res0}, 40'h0);
            rst_seen = 1'b0;
         end
         chk("handshake_match", 40'({out_valid_w[1], in_ready_w[1]}),
             40'({out_valid_w[0], in_ready_w[0]}));
         if (out_valid_w[0]) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_output: got result %h with out_valid, required no output", res0);
            end else begin
               chk("ftz0_out", 40'({flg0, res0}), 40'(sb[0][19:0]));
               chk("ftz1_out", 40'({flg1, res1}), 40'(sb[0][39:20]));
               if (out_ready) void'(sb.pop_front());
            end
         end
         if (in_valid && in_ready_w[0])
            sb.push_back({model(operand_a, rnd_mode, 1'b1), model(operand_a, rnd_mode, 1'b0)});
      end
   end

   task automatic send(input logic [31:0] a, input logic [2:0] rm);
      int waited = 0;
      operand_a = a;
      rnd_mode  = rm;
      in_valid  = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready_w[0]) break;
         waited++;
         if (waited > 50) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      while (sb.size() != 0 && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] a;
      a = $urandom;
      case ($urandom_range(0, 6))
         0: a[30:23] = 8'h00;
         1: a[30:23] = 8'hFF;
         2: a[30:23] = 8'hFE;
         3: a[15:0]  = 16'h8000;
         4: a[15:0]  = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'hFFFF;
         5: a[22:0]  = '0;
         default: ;
      endcase
      return a;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NT; i++)
         chk("model_pin", 40'(model(TAB_A[i], TAB_RM[i], TAB_FTZ[i])), 40'(TAB_EXP[i]));

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Two-cycle latency with out_ready held high.
      out_ready = 1'b1;
      send(32'h3F800000, 3'd0);
      @(negedge clk);
      chk("lat_cycle1_out_valid", 40'(out_valid_w), 40'h0);
      @(negedge clk);
      chk("lat_cycle2_out_valid", 40'(out_valid_w), 40'h3);
      chk("lat_result", 40'({flg0, res0}), 40'h0_3F80);
      @(posedge clk);
      #1;
      drain();

      for (int i = 0; i < NT; i++) send(TAB_A[i], TAB_RM[i]);
      drain();

      // Backpressure: two accepts fill the pipe, then three more queue up.
      out_ready = 1'b0;
      send(32'h40490FDB, 3'd0);
      send(32'hC0490FDB, 3'd2);
      @(negedge clk);
      chk("bp_in_ready_low", 40'(in_ready_w), 40'h0);
      @(posedge clk);
      #1;
      fork
         begin
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
         begin
            send(32'h3F81FFFF, 3'd3);
            send(32'h7F7FFFFF, 3'd0);
            send(32'h00000001, 3'd3);
         end
      join
      drain();

      // Reset with two ops in flight: neither may emerge.
      out_ready = 1'b0;
      send(32'h3F808000, 3'd0);
      send(32'h3F818000, 3'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;

      // Random operands, modes, input gaps and output stalls.
      fork
         begin
            repeat (700) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(rand_op(), 3'($urandom_range(0, 7)));
            end
         end
      join
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fp32_to_bf16_pipe.md
Name: fp32_to_bf16_pipe

Overview:
Two-stage pipelined FP32 to BF16 narrowing converter with IEEE-754 rounding and exception flags. It is the return-path companion of the accelerator's BF16 to FP32 widening stage: it consumes FP32 results from the FP32 datapath and produces BF16 for writeback. It uses a valid/ready handshake so downstream backpressure stalls the pipe without losing data.

Parameters:
FTZ, 0, 1 = subnormal inputs flush to signed zero; 0 = subnormals are rounded normally.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand_a and rnd_mode are valid
in_ready  out  1  stage 1 can accept this cycle
operand_a  in  32  FP32 input
rnd_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
out_valid  out  1  result and flags are valid
out_ready  in  1  downstream accepts this cycle
result  out  16  BF16 output
invalid  out  1  signaling NaN input
overflow  out  1  rounding carried the exponent to 0xFF
underflow  out  1  tiny and inexact
inexact  out  1  discarded bits were nonzero, or overflow occurred

Behaviour:
- Reset: s1_valid = s2_valid = 0. out_valid, result and all flags are 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation: all in-flight ops are dropped. No output is produced for them.
- Handshake:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - result and flags are held stable while out_valid && !out_ready.
- Advance rules:
  - Stage 2 loads when !s2_valid || out_ready.
  - Stage 1 loads when !s1_valid || stage 2 loads.
  - in_ready = !s1_valid || stage 2 loads. This is combinational and must not depend on in_valid.
- Latency is 2 cycles from accept to out_valid when out_ready = 1. Throughput is 1 per cycle.
- A full pipe with out_ready = 0 holds exactly 2 ops. Simultaneous accept and emit in the same cycle is legal and loses nothing.
- Stage 1 registers:
  - Input fields: s = a[31], e = a[30:23], m = a[22:0].
  - Class: zero, subnormal, normal, inf, qNaN, sNaN.
  - Rounding bits: kept mantissa k = m[22:16], guard g = m[15], sticky st = |m[14:0].
  - Round-increment bit inc:
    - RNE: g & (st | k[0])
    - RTZ: 0
    - RDN: s & (g | st)
    - RUP: !s & (g | st)
    - RMM: g
- Stage 2 forms the result and flags:
  - Finite rounding: {e', k'} = {e, k} + inc (15-bit add). result = {s, e', k'}.
  - Overflow: if e' = 0xFF after the add, then overflow = 1 and inexact = 1, and result = signed infinity.
  - inexact = g | st for finite inputs.
  - Tininess is detected before rounding: underflow = (e == 0) & inexact.
  - Zero: result = {s, 15'b0}, no flags.
  - Inf: result = {s, 8'hFF, 7'b0}, no flags.
  - NaN: result = 16'h7FC0 (canonical, sign dropped). invalid = 1 only if m[22] = 0 and m != 0.
  - Subnormal with FTZ = 1: result = {s, 15'b0}, underflow = 1, inexact = 1.
- Flags are per-result and are not accumulated.

Decomposition:
- bf16_pkg:
  - rnd_mode_e enum.
  - Constants BF16_QNAN = 16'h7FC0, FP32_EXP_W = 8, FP32_MAN_W = 23, BF16_MAN_W = 7.
  - fp_class_e enum.
  - Packed struct fp_flags_t {invalid, overflow, underflow, inexact}.
- Sub-module bf16_round_decide: combinational; inputs s, k[0], g, st, rnd_mode; output inc. It is reusable by other narrowing stages.

Test Plan:
- 0x3F800000 with RNE -> 0x3F80, no flags. out_valid is high exactly 2 cycles after accept with out_ready held at 1.
- Ties under RNE:
  - 0x3F808000 -> 0x3F80, inexact.
  - 0x3F818000 -> 0x3F82, inexact.
  - 0x3F81FFFF with RTZ -> 0x3F81, inexact. With RUP -> 0x3F82, inexact.
- Overflow edge 0x7F7FFFFF:
  - RNE -> 0x7F80, overflow + inexact.
  - RTZ -> 0x7F7F, inexact only.
  - 0xFF7FFFFF with RDN -> 0xFF80, overflow + inexact.
- NaN and infinity:
  - sNaN 0x7FA00000 -> 0x7FC0, invalid.
  - qNaN 0xFFC00001 -> 0x7FC0, no flags.
  - 0xFF800000 -> 0xFF80, no flags.
- Subnormal 0x00000001 with FTZ = 0:
  - RNE -> 0x0000, underflow + inexact.
  - RUP -> 0x0001, underflow + inexact.
  - With FTZ = 1 and RUP -> 0x0000, underflow + inexact.
- Backpressure:
  - Stream 5 ops with out_ready = 0 for 4 cycles. in_ready falls after 2 accepts. All 5 results emerge in order with no duplicates.
  - Assert reset with 2 ops in flight. out_valid = 0 the next cycle and those ops never appear.
